// File: rtl/reg_file_mp_pkg.sv
// regfile_pkg: shared constants, clear-FSM state type and write-priority
// helper for the reg_file_mp register file.
package regfile_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned DEPTH_DEF = 32;
  // Upper bound on write ports handled by the priority helper.
  localparam int unsigned MAX_PORTS = 8;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  typedef enum logic [0:0] {
    IDLE  = ST_IDLE,
    CLEAR = ST_CLEAR
  } clr_state_t;

  // One-hot of the highest-index set bit: the winning write port.
  function automatic logic [MAX_PORTS-1:0] wr_prio_onehot(input logic [MAX_PORTS-1:0] hit);
    logic [MAX_PORTS-1:0] oh;
    oh = '0;
    for (int k = 0; k < int'(MAX_PORTS); k++) begin
      if (hit[k]) begin
        oh    = '0;
        oh[k] = 1'b1;
      end
    end
    return oh;
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if: decode/writeback side bus of reg_file_mp.
//   master: drives read/write/issue/clear requests (pipeline side)
//   slave : the register file
interface reg_file_mp_if #(
  parameter int unsigned XLEN   = regfile_pkg::XLEN_DEF,
  parameter int unsigned DEPTH  = regfile_pkg::DEPTH_DEF,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 2
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [NUM_RD*AW-1:0]   rd_adr;
  logic [NUM_RD*XLEN-1:0] rd_data;
  logic [NUM_RD-1:0]      rd_busy;
  logic [NUM_WR-1:0]      wr_en;
  logic [NUM_WR*AW-1:0]   wr_adr;
  logic [NUM_WR*XLEN-1:0] wr_data;
  logic                   iss_en;
  logic [AW-1:0]          iss_adr;
  logic                   clr_req;
  logic                   clr_busy;
  logic                   clr_done;

  modport master (
    output rd_adr, wr_en, wr_adr, wr_data, iss_en, iss_adr, clr_req,
    input  rd_data, rd_busy, clr_busy, clr_done
  );

  modport slave (
    input  rd_adr, wr_en, wr_adr, wr_data, iss_en, iss_adr, clr_req,
    output rd_data, rd_busy, clr_busy, clr_done
  );
endinterface

// File: rtl/reg_file_mp_scoreboard.sv
// reg_scoreboard: per-register busy bits for hazard detection.
//   set_en/set_adr : mark register busy (issue)
//   rel_en/rel_adr : release on writeback, one per write port
//   clr_en/clr_adr : soft-clear one entry (overrides everything else)
//   rd_adr/rd_busy : combinational busy lookup per read port
// Register 0 is never marked busy.
module reg_scoreboard #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          set_en,
  input  logic [$clog2(DEPTH)-1:0]      set_adr,
  input  logic [NUM_WR-1:0]             rel_en,
  input  logic [NUM_WR*$clog2(DEPTH)-1:0] rel_adr,
  input  logic                          clr_en,
  input  logic [$clog2(DEPTH)-1:0]      clr_adr,
  input  logic [NUM_RD*$clog2(DEPTH)-1:0] rd_adr,
  output logic [NUM_RD-1:0]             rd_busy
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [DEPTH-1:0] busy;

  // Release first, then set: a new issue is younger than the writeback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else if (clr_en) begin
      busy[clr_adr] <= 1'b0;
    end else begin
      for (int k = 0; k < int'(NUM_WR); k++) begin
        if (rel_en[k] && (rel_adr[k*AW +: AW] != '0)) busy[rel_adr[k*AW +: AW]] <= 1'b0;
      end
      if (set_en && (set_adr != '0)) busy[set_adr] <= 1'b1;
    end
  end

  always_comb begin
    rd_busy = '0;
    for (int i = 0; i < int'(NUM_RD); i++) rd_busy[i] = busy[rd_adr[i*AW +: AW]];
  end

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port integer register file with busy scoreboard,
// multi-cycle soft-clear sequencer and optional write-to-read bypass.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : reg_file_mp_if.slave (reads, writes, issue, clear control)
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write data forwarded
// to matching read ports; suppressed while clearing).
module reg_file_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 2
) (
  input logic          clk,
  input logic          rst,
  reg_file_mp_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  clr_state_t    state, state_next;
  logic [AW-1:0] cnt, cnt_next;
  logic          done_next;
  logic          clr_busy_q, clr_done_q;
  logic          idle;

  logic [XLEN-1:0] mem [DEPTH];
  logic [AW-1:0]   wa  [NUM_WR];
  logic [XLEN-1:0] wd  [NUM_WR];
  logic [AW-1:0]   ra  [NUM_RD];

  assign idle = (state == IDLE);

  for (genvar k = 0; k < int'(NUM_WR); k++) begin : g_wr
    assign wa[k] = bus.wr_adr[k*AW +: AW];
    assign wd[k] = bus.wr_data[k*XLEN +: XLEN];
  end

  // Clear sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      clr_busy_q <= (state_next == CLEAR);
      clr_done_q <= done_next;
    end
  end

  // Clear sequencer next state; entry 0 is constant so the walk starts at 1.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    done_next  = 1'b0;
    if (state == IDLE) begin
      if (bus.clr_req) begin
        state_next = CLEAR;
        cnt_next   = AW'(1);
      end
    end else begin
      if (cnt == AW'(DEPTH - 1)) begin
        state_next = IDLE;
        cnt_next   = '0;
        done_next  = 1'b1;
      end else begin
        cnt_next = cnt + AW'(1);
      end
    end
  end

  assign bus.clr_busy = clr_busy_q;
  assign bus.clr_done = clr_done_q;

  // Storage: later ports overwrite earlier ones, giving high-index priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (idle) begin
      for (int k = 0; k < int'(NUM_WR); k++) begin
        if (bus.wr_en[k] && (wa[k] != '0)) mem[wa[k]] <= wd[k];
      end
    end else begin
      mem[cnt] <= '0;
    end
  end

  // Read ports.
  for (genvar i = 0; i < int'(NUM_RD); i++) begin : g_rd
    logic [XLEN-1:0] stored;

    assign ra[i]  = bus.rd_adr[i*AW +: AW];
    assign stored = (ra[i] == '0) ? '0 : mem[ra[i]];

`ifdef REGFILE_BYPASS_EN
    logic [MAX_PORTS-1:0] hit;
    logic [MAX_PORTS-1:0] win;
    logic [XLEN-1:0]      fwd;

    always_comb begin
      hit = '0;
      for (int k = 0; k < int'(NUM_WR); k++) begin
        hit[k] = idle && bus.wr_en[k] && (wa[k] != '0) && (wa[k] == ra[i]);
      end
    end

    assign win = wr_prio_onehot(hit);

    always_comb begin
      fwd = '0;
      for (int k = 0; k < int'(NUM_WR); k++) begin
        if (win[k]) fwd = fwd | wd[k];
      end
    end

    assign bus.rd_data[i*XLEN +: XLEN] = (|hit) ? fwd : stored;
`else
    assign bus.rd_data[i*XLEN +: XLEN] = stored;
`endif
  end

  reg_scoreboard #(
    .DEPTH (DEPTH),
    .NUM_RD(NUM_RD),
    .NUM_WR(NUM_WR)
  ) u_sb (
    .clk    (clk),
    .rst    (rst),
    .set_en (idle && bus.iss_en),
    .set_adr(bus.iss_adr),
    .rel_en ({NUM_WR{idle}} & bus.wr_en),
    .rel_adr(bus.wr_adr),
    .clr_en (!idle),
    .clr_adr(cnt),
    .rd_adr (bus.rd_adr),
    .rd_busy(bus.rd_busy)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed self-checking bench for reg_file_mp.
// Two instances: default 32x32 2R/2W, and a 16-entry 3R/1W build.
module tb_reg_file_mp;

  localparam int unsigned AW  = 5;
  localparam int unsigned AW2 = 4;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  reg_file_mp_if #(.XLEN(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2)) bus ();
  reg_file_mp_if #(.XLEN(32), .DEPTH(16), .NUM_RD(3), .NUM_WR(1)) bus2 ();

  reg_file_mp #(.XLEN(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  reg_file_mp #(.XLEN(32), .DEPTH(16), .NUM_RD(3), .NUM_WR(1)) dut16 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setrd(input int p, input logic [AW-1:0] a);
    bus.rd_adr[p*AW +: AW] = a;
  endtask

  task automatic wr(input int p, input logic [AW-1:0] a, input logic [31:0] d);
    bus.wr_en[p]               = 1'b1;
    bus.wr_adr[p*AW +: AW]     = a;
    bus.wr_data[p*32 +: 32]    = d;
  endtask

  function automatic logic [31:0] rdat(input int p);
    return bus.rd_data[p*32 +: 32];
  endfunction

  function automatic logic [31:0] rdat2(input int p);
    return bus2.rd_data[p*32 +: 32];
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nbusy, ndone, done_idx;

    bus.rd_adr = '0;  bus.wr_en = '0;  bus.wr_adr = '0;  bus.wr_data = '0;
    bus.iss_en = 1'b0; bus.iss_adr = '0; bus.clr_req = 1'b0;
    bus2.rd_adr = '0; bus2.wr_en = '0; bus2.wr_adr = '0; bus2.wr_data = '0;
    bus2.iss_en = 1'b0; bus2.iss_adr = '0; bus2.clr_req = 1'b0;

    // Reset state
    #3;
    check("rst_clr_busy", 64'(bus.clr_busy), 64'd0);
    check("rst_clr_done", 64'(bus.clr_done), 64'd0);
    #9 rst = 1'b0;
    tick();

    // 1: all registers zero and idle after reset; x0 not writable
    for (int a = 0; a < 32; a++) begin
      setrd(0, AW'(a));
      setrd(1, AW'(31 - a));
      #1;
      check($sformatf("t1_rd0_x%0d", a), 64'(rdat(0)), 64'd0);
      check($sformatf("t1_rd1_x%0d", 31 - a), 64'(rdat(1)), 64'd0);
      check($sformatf("t1_busy_%0d", a), 64'(bus.rd_busy), 64'd0);
      tick();
    end
    wr(0, 5'd0, 32'hDEADBEEF);
    setrd(0, 5'd0);
    tick();
    bus.wr_en = '0;
    #1;
    check("t1_x0_after_write", 64'(rdat(0)), 64'd0);

    // 2: write-port priority and bypass
    wr(0, 5'd5, 32'h55);
    tick();
    bus.wr_en = '0;
    wr(0, 5'd5, 32'h11);
    wr(1, 5'd5, 32'h22);
    setrd(0, 5'd5);
    #1;
    check("t2_same_cycle", 64'(rdat(0)), BYP ? 64'h22 : 64'h55);
    tick();
    bus.wr_en = '0;
    #1;
    check("t2_next_cycle", 64'(rdat(0)), 64'h22);
    wr(0, 5'd6, 32'h66);
    wr(1, 5'd9, 32'h99);
    tick();
    bus.wr_en = '0;
    setrd(0, 5'd6);
    setrd(1, 5'd9);
    #1;
    check("t2_dual_p0", 64'(rdat(0)), 64'h66);
    check("t2_dual_p1", 64'(rdat(1)), 64'h99);

    // 3: scoreboard
    setrd(0, 5'd7);
    setrd(1, 5'd7);
    bus.iss_en = 1'b1; bus.iss_adr = 5'd7;
    tick();
    bus.iss_en = 1'b0;
    #1;
    check("t3_busy_c1", 64'(bus.rd_busy), 64'b11);
    tick();
    check("t3_busy_c2", 64'(bus.rd_busy), 64'b11);
    wr(1, 5'd7, 32'h77);
    tick();
    bus.wr_en = '0;
    #1;
    check("t3_busy_released", 64'(bus.rd_busy), 64'b00);
    check("t3_x7_data", 64'(rdat(0)), 64'h77);
    bus.iss_en = 1'b1; bus.iss_adr = 5'd7;
    wr(0, 5'd7, 32'h78);
    tick();
    bus.iss_en = 1'b0; bus.wr_en = '0;
    #1;
    check("t3_set_wins", 64'(bus.rd_busy[0]), 64'd1);
    wr(0, 5'd7, 32'h79);
    tick();
    bus.wr_en = '0;
    #1;
    check("t3_release2", 64'(bus.rd_busy[0]), 64'd0);
    bus.iss_en = 1'b1; bus.iss_adr = 5'd0;
    setrd(0, 5'd0);
    tick();
    bus.iss_en = 1'b0;
    #1;
    check("t3_x0_never_busy", 64'(bus.rd_busy[0]), 64'd0);

    // 4: full soft clear
    for (int i = 1; i < 32; i++) begin
      wr(0, AW'(i), 32'h1000 + 32'(i));
      tick();
    end
    bus.wr_en = '0;
    setrd(0, 5'd31);
    #1;
    check("t4_load_x31", 64'(rdat(0)), 64'h101F);
    bus.iss_en = 1'b1; bus.iss_adr = 5'd4;
    tick();
    bus.iss_en = 1'b0;
    setrd(0, 5'd4);
    #1;
    check("t4_x4_busy", 64'(bus.rd_busy[0]), 64'd1);
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    nbusy = 0; ndone = 0; done_idx = -1;
    for (int c = 0; c < 40; c++) begin
      if (c == 10) begin
        wr(1, 5'd3, 32'h333);
        setrd(0, 5'd3);
        setrd(1, 5'd31);
        #1;
        check("t4_bypass_suppressed", 64'(rdat(0)), 64'd0);
        check("t4_partial_x31", 64'(rdat(1)), 64'h101F);
      end
      if (c == 11) bus.wr_en = '0;
      if (c == 12) begin bus.iss_en = 1'b1; bus.iss_adr = 5'd9; end
      if (c == 13) bus.iss_en = 1'b0;
      if (bus.clr_busy) nbusy++;
      if (bus.clr_done) begin ndone++; done_idx = c; end
      tick();
    end
    check("t4_busy_cycles", 64'(nbusy), 64'd31);
    check("t4_done_pulses", 64'(ndone), 64'd1);
    check("t4_done_idx", 64'(done_idx), 64'd31);
    for (int a = 0; a < 32; a++) begin
      setrd(0, AW'(a));
      setrd(1, AW'(a));
      #1;
      check($sformatf("t4_zero_x%0d", a), 64'(rdat(0)), 64'd0);
      check($sformatf("t4_nobusy_x%0d", a), 64'(bus.rd_busy), 64'd0);
      tick();
    end

    // 5: asynchronous reset mid-clear
    for (int i = 1; i <= 12; i++) begin
      wr(1, AW'(i), 32'hA0 + 32'(i));
      tick();
    end
    bus.wr_en = '0;
    bus.iss_en = 1'b1; bus.iss_adr = 5'd20;
    tick();
    bus.iss_en = 1'b0;
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    repeat (9) tick();
    setrd(0, 5'd12);
    #1;
    check("t5_busy_pre", 64'(bus.clr_busy), 64'd1);
    check("t5_x12_pre", 64'(rdat(0)), 64'hAC);
    #1 rst = 1'b1;
    #1;
    check("t5_busy_async_drop", 64'(bus.clr_busy), 64'd0);
    check("t5_done_low", 64'(bus.clr_done), 64'd0);
    check("t5_x12_zero", 64'(rdat(0)), 64'd0);
    setrd(1, 5'd20);
    #1;
    check("t5_x20_not_busy", 64'(bus.rd_busy[1]), 64'd0);
    for (int a = 0; a < 32; a++) begin
      setrd(0, AW'(a));
      #1;
      check($sformatf("t5_zero_x%0d", a), 64'(rdat(0)), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();

    // 6: 16-entry, 3 read / 1 write build
    bus2.wr_en = 1'b1; bus2.wr_adr = 4'd15; bus2.wr_data = 32'hABCD;
    tick();
    bus2.wr_en = '0;
    for (int p = 0; p < 3; p++) bus2.rd_adr[p*AW2 +: AW2] = 4'd15;
    #1;
    for (int p = 0; p < 3; p++) check($sformatf("t6_x15_p%0d", p), 64'(rdat2(p)), 64'hABCD);
    bus2.clr_req = 1'b1;
    tick();
    bus2.clr_req = 1'b0;
    nbusy = 0; ndone = 0; done_idx = -1;
    for (int c = 0; c < 20; c++) begin
      if (bus2.clr_busy) nbusy++;
      if (bus2.clr_done) begin ndone++; done_idx = c; end
      tick();
    end
    check("t6_busy_cycles", 64'(nbusy), 64'd15);
    check("t6_done_pulses", 64'(ndone), 64'd1);
    check("t6_done_idx", 64'(done_idx), 64'd15);
    check("t6_x15_cleared", 64'(rdat2(2)), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port integer register file for the pipelined core. It generalises the single-write, dual-read register file in four ways:
- configurable width, depth and port counts
- per-register scoreboard (busy bits) for hazard detection
- multi-cycle soft-clear sequencer
- optional write-to-read bypass
Sits between decode (reads, issue marking) and writeback (writes, busy release).

Parameters:
XLEN, 32, data width of each register
DEPTH, 32, number of registers; power of two, >=4
NUM_RD, 2, number of combinational read ports
NUM_WR, 2, number of write ports; higher index has priority
AW, $clog2(DEPTH), address width (derived, not overridable)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
rd_adr  input  NUM_RD*AW  read addresses, port i at [i*AW +: AW]
rd_data  output  NUM_RD*XLEN  read data per port
rd_busy  output  NUM_RD  scoreboard busy bit of each addressed register
wr_en  input  NUM_WR  write enables
wr_adr  input  NUM_WR*AW  write addresses
wr_data  input  NUM_WR*XLEN  write data
iss_en  input  1  mark destination register busy (instruction issued)
iss_adr  input  AW  destination register being issued
clr_req  input  1  request soft clear of all registers
clr_busy  output  1  high while the clear sequencer is running
clr_done  output  1  one-cycle pulse when the clear completes

Behaviour:
- Reset (async, rst=1): all registers 0; all busy bits 0; FSM IDLE; clear counter 0; clr_busy=0, clr_done=0. rd_data reflects zeros immediately.
- Register 0: always reads 0, never written, never busy. Writes and issues to address 0 are ignored.
- Reads: combinational. rd_data[i]=mem[rd_adr[i]]; rd_busy[i]=busy[rd_adr[i]].
- Writes: take effect at the rising edge when wr_en[k]=1 and wr_adr[k]!=0. Write latency to a read port is one cycle (see optional feature).
- Write conflicts: several ports to the same address in one cycle -> the highest-index enabled port wins.
- Scoreboard:
  - iss_en sets busy[iss_adr] at the next edge.
  - Any enabled write clears busy[wr_adr] at the next edge.
  - Set and clear of the same address in one cycle -> set wins, because the new issue is younger than the writeback.
- Clear FSM, states IDLE and CLEAR:
  - IDLE with clr_req=1 -> CLEAR. Counter loads 1; clr_busy=1 from the next cycle.
  - CLEAR: each cycle, mem[cnt] <= 0 and busy[cnt] <= 0; cnt increments.
  - When cnt==DEPTH-1 has been cleared -> IDLE, with clr_done=1 for exactly that next cycle.
  - Total clear duration: DEPTH-1 cycles.
  - In CLEAR, all wr_en and iss_en are ignored (dropped, not queued). clr_req is ignored.
  - Reads in CLEAR return current contents, so partially cleared state is visible.
- clr_req asserted in the same cycle as a write: the write commits, then the clear starts.
- Reset mid-clear: the sequencer aborts immediately to IDLE and all state is zeroed.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: a read port whose address matches an enabled write (address != 0) in the same cycle returns that wr_data combinationally, using the same highest-index priority. rd_busy still shows the registered busy bit.
- Not defined: reads return the stored value; new data is visible one cycle after the write.
- Bypass is suppressed while in CLEAR, since writes are dropped there.

Decomposition:
- Package regfile_pkg holds:
  - the default XLEN/DEPTH constants
  - the clear FSM state enum typedef clr_state_t {IDLE, CLEAR}
  - a function for the highest-priority write-port match
- Sub-module reg_scoreboard contains the busy-bit array, its set/clear priority and the read-side busy muxing. Storage and the clear FSM stay in the top module.

Test Plan:
1. Reset then read all 32 addresses on both ports -> all rd_data=0, rd_busy=0. Write 0xDEADBEEF to x0 -> x0 still reads 0.
2. Write port0 x5=0x11, port1 x5=0x22 in the same cycle -> the next cycle x5 reads 0x22. Same cycle with bypass on -> reads 0x22; with bypass off -> reads the old value.
3. iss_en x7, then write x7 two cycles later -> rd_busy high for exactly two cycles, then low. iss_en x7 together with a write to x7 -> busy stays 1.
4. Load x1..x31 with nonzero values, pulse clr_req -> clr_busy high 31 cycles, clr_done pulses once, all registers read 0. A write to x3 during the clear is dropped.
5. Assert rst asynchronously mid-clear (cnt=10) -> clr_busy drops without waiting for a clock edge; all registers and busy bits read 0.
6. DEPTH=16, NUM_RD=3, NUM_WR=1 build -> a write to x15 reads back on all three ports. The clear completes in 15 cycles.
